// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the round-robin memory arbiter.
// Optional feature: MEM_ARB_TIMEOUT_EN enables the ISSUE-state timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_e;

  localparam int NUM_REQ_DEF = 4;
  localparam int DEPTH_DEF   = 32;
  localparam int WIDTH_DEF   = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TIMEOUT_DEF = 15;
`endif

  // Index width that stays at least one bit for degenerate counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping from NUM_REQ-1 back to 0.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   grant_o
);

  int unsigned idx;

  // Scan NUM_REQ positions starting at the pointer; keep the first hit.
  always_comb begin
    any_o   = 1'b0;
    grant_o = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!any_o && req_valid_i[idx]) begin
        any_o   = 1'b1;
        grant_o = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ
// requesters. One transaction in flight: IDLE -> ISSUE -> RESP -> IDLE.
// Optional feature: MEM_ARB_TIMEOUT_EN bounds the ISSUE wait to TIMEOUT
// cycles and flags the abandoned request with req_err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ    = NUM_REQ_DEF,
  parameter  int DEPTH      = DEPTH_DEF,
  parameter  int WIDTH      = WIDTH_DEF,
`ifdef MEM_ARB_TIMEOUT_EN
  parameter  int TIMEOUT    = TIMEOUT_DEF,
`endif
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int IDX_W      = idx_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_wr_rd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [WIDTH-1:0]              req_rdata,
  output logic                          req_err,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          mem_valid,
  output logic                          mem_wr_rd,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [WIDTH-1:0]              mem_wdata,
  input  logic                          mem_ready,
  input  logic [WIDTH-1:0]              mem_rdata
);

  arb_state_e state_q, state_d;

  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  wr_rd_q, wr_rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic [NUM_REQ-1:0]    ready_q, ready_d;
  logic [NUM_REQ-1:0]    grant_oh;

  logic                  pick_any;
  logic [IDX_W-1:0]      pick_grant;
  logic [IDX_W-1:0]      pick_next;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (idx_w(TIMEOUT + 1) < 4) ? 4 : idx_w(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  mem_arb_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req_valid_i(req_valid),
    .ptr_i      (ptr_q),
    .any_o      (pick_any),
    .grant_o    (pick_grant)
  );

  assign pick_next = (pick_grant == IDX_W'(NUM_REQ - 1)) ? '0 : pick_grant + 1'b1;
  assign grant_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;

  // Next-state and datapath updates for the single in-flight transaction.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    mem_valid_d = mem_valid_q;
    wr_rd_d     = wr_rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ready_d     = '0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        mem_valid_d = 1'b0;
        if (pick_any) begin
          grant_d     = pick_grant;
          wr_rd_d     = req_wr_rd[pick_grant];
          addr_d      = req_addr[pick_grant*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d     = req_wdata[pick_grant*WIDTH +: WIDTH];
          mem_valid_d = 1'b1;
          ptr_d       = pick_next;
          state_d     = ISSUE;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end

      ISSUE: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          ready_d     = grant_oh;
          if (!wr_rd_q) begin
            rdata_d = mem_rdata;
          end
          state_d = RESP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // cnt_q counts completed ISSUE cycles, so TIMEOUT-1 here means the
        // TIMEOUT-th cycle is ending without a memory response.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_valid_d = 1'b0;
          ready_d     = grant_oh;
          err_d       = 1'b1;
          rdata_d     = '0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      mem_valid_q <= 1'b0;
      wr_rd_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ready_q     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      mem_valid_q <= mem_valid_d;
      wr_rd_q     <= wr_rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign req_ready = ready_q;
  assign req_rdata = rdata_q;
  assign grant_id  = grant_q;
  assign mem_valid = mem_valid_q;
  assign mem_wr_rd = wr_rd_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign req_err   = err_q;
`else
  assign req_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: timeline-based reference model plus directed
// scenarios (reset, write/read, contention, wrap, abort, stalled memory).
module tb_mem_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 32;
  localparam int W     = 8;
  localparam int AW    = 5;
  localparam int IW    = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_wr_rd = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*W-1:0]  req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic [W-1:0]    req_rdata;
  logic            req_err;
  logic [IW-1:0]   grant_id;
  logic            mem_valid;
  logic            mem_wr_rd;
  logic [AW-1:0]   mem_addr;
  logic [W-1:0]    mem_wdata;
  logic            mem_ready;
  logic [W-1:0]    mem_rdata = '0;

  logic            mem_ready_q = 1'b0;
  logic            ghost = 1'b0;
  logic            stall = 1'b0;
  logic [W-1:0]    mem_arr [DEPTH];

  int total = 0;
  int bad   = 0;

  mem_arbiter #(
`ifdef MEM_ARB_TIMEOUT_EN
    .TIMEOUT(15),
`endif
    .NUM_REQ(N),
    .DEPTH  (DEPTH),
    .WIDTH  (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_wr_rd(req_wr_rd),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .req_rdata(req_rdata),
    .req_err  (req_err),
    .grant_id (grant_id),
    .mem_valid(mem_valid),
    .mem_wr_rd(mem_wr_rd),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: answers one cycle after seeing mem_valid; ghost injects a stray ready.
  assign mem_ready = mem_ready_q | ghost;

  initial for (int i = 0; i < DEPTH; i++) mem_arr[i] = '0;

  always @(posedge clk) begin
    if (rst) begin
      mem_ready_q <= 1'b0;
    end else if (mem_valid && !mem_ready_q && !stall) begin
      mem_ready_q <= 1'b1;
      if (mem_wr_rd) mem_arr[mem_addr] <= mem_wdata;
      else           mem_rdata <= mem_arr[mem_addr];
    end else begin
      mem_ready_q <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: a transaction is a timeline (grant edge, completion edge).
  int              cyc = 0;
  bit              m_act = 1'b0;
  int              m_tg = 0;
  int              m_done = -1;
  bit              m_to = 1'b0;
  int              m_g = 0;
  int              m_ptr = 0;
  logic            m_wr = 1'b0;
  logic [AW-1:0]   m_addr = '0;
  logic [W-1:0]    m_wdata = '0;
  logic [W-1:0]    m_rdata = '0;
  logic [W-1:0]    m_mem [DEPTH];
  logic [2*N-1:0]  m_dbl;
  int              m_j;

  initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_act = 1'b0; m_done = -1; m_to = 1'b0; m_g = 0; m_ptr = 0;
      m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (!m_act) begin
      if (|req_valid) begin
        m_dbl = {req_valid, req_valid} >> m_ptr;
        m_j = 0;
        while (!m_dbl[m_j]) m_j++;
        m_g     = (m_ptr + m_j) % N;
        m_wr    = req_wr_rd[m_g];
        m_addr  = req_addr[m_g*AW +: AW];
        m_wdata = req_wdata[m_g*W +: W];
        m_ptr   = (m_g + 1) % N;
        m_act   = 1'b1;
        m_tg    = cyc;
        m_done  = -1;
        m_to    = 1'b0;
      end
    end else if (m_done >= 0) begin
      m_act = 1'b0;
    end else if (mem_ready) begin
      m_done = cyc;
      if (m_wr) m_mem[m_addr] = m_wdata;
      else      m_rdata = m_mem[m_addr];
    end
`ifdef MEM_ARB_TIMEOUT_EN
    else if (cyc - m_tg == 15) begin
      m_done  = cyc;
      m_to    = 1'b1;
      m_rdata = '0;
    end
`endif
  end

  logic [N-1:0] e_rdy;

  // Compare every cycle, half a period after the updating edge.
  always @(negedge clk) begin
    e_rdy = (m_act && m_done == cyc) ? (4'b0001 << m_g) : 4'b0000;
    chk("req_ready", req_ready, e_rdy);
    chk("req_err",   req_err,   (e_rdy != 0) && m_to);
    chk("mem_valid", mem_valid, m_act && (m_done < 0));
    chk("grant_id",  grant_id,  m_g);
    chk("mem_wr_rd", mem_wr_rd, m_wr);
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("req_rdata", req_rdata, m_rdata);
  end

  task automatic set_cmd(input int i, input bit wr, input int a, input int d);
    req_wr_rd[i]          = wr;
    req_addr[i*AW +: AW]  = a[AW-1:0];
    req_wdata[i*W +: W]   = d[W-1:0];
  endtask

  task automatic wait_any(input int maxc, output int id, output int cnt, output bit ok);
    ok = 1'b0; id = -1; cnt = 0;
    for (int n = 1; n <= maxc && !ok; n++) begin
      @(negedge clk);
      if (|req_ready) begin
        ok  = 1'b1;
        cnt = n;
        for (int b = 0; b < N; b++) if (req_ready[b]) id = b;
      end
    end
  endtask

  task automatic do_txn(input int i, input bit wr, input int a, input int d,
                        output int cnt, output bit ok);
    int id;
    set_cmd(i, wr, a, d);
    req_valid[i] = 1'b1;
    wait_any(20, id, cnt, ok);
    chk("txn_done", ok, 1);
    chk("txn_id", id, i);
    req_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int cont_exp [5] = '{0, 1, 2, 3, 0};
  int wrap_exp [4] = '{3, 0, 1, 3};

  initial begin : main
    int id, cnt, rc;
    bit ok;

    // Reset held two cycles with every requester asserting.
    for (int i = 0; i < N; i++) set_cmd(i, 1, 8 + i, 'h10 + i);
    req_valid = 4'b1111;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_grant", grant_id, 0);
    end
    rst = 1'b0;

    // Contention with everyone holding valid: 0,1,2,3,0 at 4-cycle spacing.
    for (int k = 0; k < 5; k++) begin
      wait_any(20, id, cnt, ok);
      chk("cont_done", ok, 1);
      chk("cont_order", id, cont_exp[k]);
      chk("cont_gap", cnt, (k == 0) ? 3 : 4);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);

    // Stray memory ready while idle must not produce a completion.
    ghost = 1'b1;
    rc = 0;
    repeat (3) begin
      @(negedge clk);
      if (|req_ready) rc++;
    end
    ghost = 1'b0;
    chk("ghost_no_ready", rc, 0);

    // Single write then read from requester 0.
    do_txn(0, 1, 5, 'hA5, cnt, ok);
    chk("wr_latency", cnt, 3);
    do_txn(0, 0, 5, 0, cnt, ok);
    chk("rd_latency", cnt, 4);
    chk("rd_data", req_rdata, 'hA5);

    // Wrap from pointer 3 and late arrival of requester 1.
    repeat (2) @(negedge clk);
    do_reset();
    do_txn(2, 1, 3, 'h3C, cnt, ok);
    chk("ptr_setup_latency", cnt, 3);
    set_cmd(3, 0, 5, 0);
    set_cmd(0, 1, 1, 'h33);
    set_cmd(1, 0, 1, 0);
    req_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      wait_any(20, id, cnt, ok);
      chk("wrap_done", ok, 1);
      chk("wrap_order", id, wrap_exp[k]);
      if (k == 0) chk("wrap_rd3", req_rdata, 'hA5);
      if (k == 1) begin
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1;
      end
      if (k == 2) begin
        chk("wrap_rd1", req_rdata, 'h33);
        req_valid[1] = 1'b0;
      end
    end
    req_valid = '0;

    // Reset while the memory request is outstanding.
    repeat (3) @(negedge clk);
    set_cmd(2, 1, 7, 'h77);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("pre_abort_mem_valid", mem_valid, 1);
    chk("pre_abort_grant", grant_id, 2);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_mem_valid", mem_valid, 0);
    chk("abort_ready", req_ready, 0);
    chk("abort_grant", grant_id, 0);
    rc = 0;
    repeat (8) begin
      @(negedge clk);
      if (|req_ready) rc++;
    end
    chk("abort_no_ready", rc, 0);
    do_txn(1, 0, 7, 0, cnt, ok);
    chk("abort_write_dropped", req_rdata, 0);
    do_txn(1, 0, 5, 0, cnt, ok);
    chk("pre_stall_rd", req_rdata, 'hA5);

    // Memory never answers.
    repeat (2) @(negedge clk);
    stall = 1'b1;
    set_cmd(1, 0, 5, 0);
    req_valid[1] = 1'b1;
    wait_any(30, id, cnt, ok);
`ifdef MEM_ARB_TIMEOUT_EN
    chk("tmo_done", ok, 1);
    chk("tmo_latency", cnt, 16);
    chk("tmo_err", req_err, 1);
    chk("tmo_rdata", req_rdata, 0);
    req_valid = '0;
    @(negedge clk);
    chk("tmo_err_clear", req_err, 0);
`else
    chk("stall_no_completion", ok, 0);
    chk("stall_err", req_err, 0);
    chk("stall_mem_valid", mem_valid, 1);
`endif
    stall = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
